i2c_slave_rx: RTL

Write-only I2C target that sits directly downstream of `i2c_master` on the shared `sda`/`scl` pair. It oversamples the bus with `clk` and detects START and STOP. It receives the three-byte frame (device ID, register address, data byte), drives ACK in each ninth-bit slot, and commits the data byte into an internal byte register file. A read port and per-frame status pulses let the rest of the chip consume the written configuration.

---
 rtl/i2c_pkg.sv | 41 ++++
 rtl/i2c_bus_sync.sv | 43 ++++
 rtl/i2c_slave_rx.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the write-only I2C target and anything that drives
// or observes its frames.
//   - i2c_state_e     : receive FSM encoding (3 bits)
//   - DEV_ID_DEFAULT  : device ID acknowledged when not overridden
//   - TIM_CLK         : clk cycles per master timing unit
//   - SLOT_*          : frame positions, in timing units from frame start
//   - ack_next()      : state that follows a given ACK slot
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ID        = 3'd1,
    ST_ID_ACK    = 3'd2,
    ST_ADDR      = 3'd3,
    ST_ADDR_ACK  = 3'd4,
    ST_DATA      = 3'd5,
    ST_DATA_ACK  = 3'd6,
    ST_WAIT_STOP = 3'd7
  } i2c_state_e;

  localparam logic [7:0] DEV_ID_DEFAULT = 8'hA0;

  localparam int TIM_CLK = 64;

  localparam int SLOT_START_FIRST = 0;
  localparam int SLOT_START_LAST  = 7;
  localparam int SLOT_ACK_ID      = 24;
  localparam int SLOT_ACK_ADDR    = 42;
  localparam int SLOT_ACK_DATA    = 60;
  localparam int SLOT_STOP_FIRST  = 62;
  localparam int SLOT_STOP_LAST   = 69;

  function automatic i2c_state_e ack_next(input i2c_state_e s);
    case (s)
      ST_ID_ACK:   return ST_ADDR;
      ST_ADDR_ACK: return ST_DATA;
      default:     return ST_WAIT_STOP;
    endcase
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchroniser and edge/event detector for the I2C pins.
// Each pin goes through two synchronising flops and one history flop; edges
// are taken between stage 2 and stage 3.
//   clk, rst          : system clock, async active-low reset (flops reset to 1)
//   scl_i, sda_i      : raw bus pins
//   scl_rise/scl_fall : one-cycle scl edge strobes
//   start_det         : sda fell while scl high
//   stop_det          : sda rose while scl high
//   sda_bit           : synchronised sda, aligned with the scl strobes
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_bit
);

  logic [2:0] scl_q;
  logic [2:0] sda_q;
  logic       scl_high;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign scl_high  = scl_q[1] & scl_q[2];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_high & ~sda_q[1] & sda_q[2];
  assign stop_det  = scl_high & sda_q[1] & ~sda_q[2];
  assign sda_bit   = sda_q[1];

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: receives {device ID, register address, data},
// ACKs each byte and commits the data byte into a 2**AW byte register file.
//   clk, rst          : system clock, async active-low reset
//   scl, sda          : I2C bus (sda open-drain, pulled up externally)
//   rd_addr, rd_data  : combinational register file read port
//   wr_en             : one-cycle pulse when a data byte is committed
//   wr_addr, wr_data  : full address byte and data byte of that commit
//   frame_err         : one-cycle pulse when a matched frame is cut short
//
// state        | meaning
// ST_IDLE      | no frame in progress, waiting for START
// ST_ID        | shifting in the device ID byte
// ST_ID_ACK    | ID matched, ACK slot
// ST_ADDR      | shifting in the register address byte
// ST_ADDR_ACK  | address ACK slot
// ST_DATA      | shifting in the data byte
// ST_DATA_ACK  | data committed, ACK slot
// ST_WAIT_STOP | frame done or not ours, ignore scl until STOP/START
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [7:0] DEV_ID   = DEV_ID_DEFAULT,
  parameter int         AW       = 5,
  parameter int         ACK_HOLD = 96
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl,
  inout  wire           sda,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          wr_en,
  output logic [7:0]    wr_addr,
  output logic [7:0]    wr_data,
  output logic          frame_err
);

  localparam int HW    = $clog2(ACK_HOLD + 1);
  localparam int DEPTH = 2 ** AW;

  logic scl_rise, scl_fall, start_det, stop_det, sda_bit;

  i2c_state_e state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [6:0]    shreg_q, shreg_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          wr_en_q, wr_en_d;
  logic          frame_err_q, frame_err_d;
  logic          oe_q, oe_d;
  logic          ack_given_q, ack_given_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    mask_q, mask_d;
  logic [7:0]    mem_q [DEPTH];

  logic       masked, ev_start, ev_stop, mid_frame, hold_expire;
  logic [7:0] byte_in;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl),
    .sda_i     (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_bit   (sda_bit)
  );

  // Our own ACK edges reach the synchroniser 2-3 clk late; keep event
  // detection blind while driving and for 3 clk after release.
  assign masked    = oe_q || (mask_q != 2'd0);
  assign ev_start  = start_det && !masked;
  assign ev_stop   = stop_det && !masked;
  assign mid_frame = (state_q == ST_ADDR) || (state_q == ST_ADDR_ACK) || (state_q == ST_DATA);

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    addr_d      = addr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    frame_err_d = 1'b0;
    oe_d        = oe_q;
    ack_given_d = ack_given_q;
    hold_d      = (hold_q != '0) ? hold_q - HW'(1) : hold_q;
    mask_d      = oe_q ? 2'd3 : ((mask_q != 2'd0) ? mask_q - 2'd1 : 2'd0);
    byte_in     = {shreg_q, sda_bit};
    hold_expire = oe_q && (hold_q == HW'(1));

    case (state_q)
      ST_ID, ST_ADDR, ST_DATA: begin
        if (scl_rise) begin
          shreg_d  = byte_in[6:0];
          bitcnt_d = bitcnt_q + 3'd1;  // wraps to 0 after the 8th bit
          if (bitcnt_q == 3'd7) begin
            ack_given_d = 1'b0;
            hold_d      = '0;
            if (state_q == ST_ID) begin
              state_d = (byte_in == DEV_ID) ? ST_ID_ACK : ST_WAIT_STOP;
            end else if (state_q == ST_ADDR) begin
              addr_d  = byte_in;
              state_d = ST_ADDR_ACK;
            end else begin
              state_d   = ST_DATA_ACK;
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = byte_in;
            end
          end
        end
      end
      ST_ID_ACK, ST_ADDR_ACK, ST_DATA_ACK: begin
        if (scl_rise && oe_q) hold_d = HW'(ACK_HOLD);
        // First fall opens the slot, second fall closes it. ack_given keeps a
        // timed-out slot from being reopened by the closing fall.
        if (scl_fall) begin
          if (!ack_given_q) begin
            oe_d        = 1'b1;
            ack_given_d = 1'b1;
          end else begin
            oe_d    = 1'b0;
            state_d = ack_next(state_q);
          end
        end
        // The master keeps scl high from the last ACK slot into STOP, so only
        // the timer can end that slot.
        if (hold_expire) begin
          oe_d = 1'b0;
          if (state_q == ST_DATA_ACK) state_d = ST_WAIT_STOP;
        end
      end
      default: oe_d = 1'b0;
    endcase

    if (ev_start) begin
      frame_err_d = mid_frame;
      state_d     = ST_ID;
      bitcnt_d    = 3'd0;
      oe_d        = 1'b0;
    end else if (ev_stop) begin
      frame_err_d = mid_frame;
      state_d     = ST_IDLE;
      oe_d        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= 3'd0;
      shreg_q     <= '0;
      addr_q      <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
      oe_q        <= 1'b0;
      ack_given_q <= 1'b0;
      hold_q      <= '0;
      mask_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      addr_q      <= addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      frame_err_q <= frame_err_d;
      oe_q        <= oe_d;
      ack_given_q <= ack_given_d;
      hold_q      <= hold_d;
      mask_q      <= mask_d;
    end
  end

  // Address bits above AW alias onto the low entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_q) begin
      mem_q[wr_addr_q[AW-1:0]] <= wr_data_q;
    end
  end

  assign sda       = oe_q ? 1'b0 : 1'bz;
  assign rd_data   = mem_q[rd_addr];
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;

endmodule
